// File: rtl/alu_ctrl_muldiv.sv
// ---------------------------------------------------------------------------
// alu_ctrl_muldiv
//
// ALU control decode plus execute unit. ALUOp/funct are decoded into a 4-bit
// ALU control code. Single-cycle ALU ops are executed and returned with a
// registered result. MULTU and DIVU are computed iteratively (one bit per
// cycle, WIDTH cycles) into the architectural HI/LO registers behind a
// valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valid_in     operation request, accepted when valid_in && ready_out
//   alu_op       0: add, 1: sub, 2/3: R-type (decode func_code)
//   func_code    R-type funct field
//   src_a/src_b  operands, captured at accept
//   ready_out    high while idle (able to accept an operation)
//   result       registered result, held until the next result_valid
//   result_valid one-cycle pulse qualifying result/zero/error/alu_ctrl
//   zero         result == 0
//   error        unknown funct or divide by zero
//   alu_ctrl     control code of the completed operation
//   hi/lo        architectural HI/LO registers
// ---------------------------------------------------------------------------
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             ready_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             zero,
  output logic             error,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] CTRL_AND   = 4'd0;
  localparam logic [3:0] CTRL_OR    = 4'd1;
  localparam logic [3:0] CTRL_ADD   = 4'd2;
  localparam logic [3:0] CTRL_SUB   = 4'd6;
  localparam logic [3:0] CTRL_SLT   = 4'd7;
  localparam logic [3:0] CTRL_MULTU = 4'd8;
  localparam logic [3:0] CTRL_DIVU  = 4'd9;
  localparam logic [3:0] CTRL_MFHI  = 4'd10;
  localparam logic [3:0] CTRL_MFLO  = 4'd11;
  localparam logic [3:0] CTRL_NOR   = 4'd12;
  localparam logic [3:0] CTRL_INV   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]       dec_ctrl;
  logic             accept;
  logic             start_mul;
  logic             start_div;
  logic             last_step;
  logic [CNT_W-1:0] count;

  // Shared iterative datapath: md_acc is the running partial product high
  // half (multiply) or the partial remainder (divide); md_q holds the
  // multiplier bits still to consume or the dividend/quotient shift register;
  // md_operand is the multiplicand or the divisor.
  logic [WIDTH-1:0] md_acc;
  logic [WIDTH-1:0] md_q;
  logic [WIDTH-1:0] md_operand;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] mul_q_next;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_borrow;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_q_next;

  // Single-cycle ops are captured at accept and executed on the following
  // edge, so every op sees its operands exactly as they were at accept.
  logic             pend_valid;
  logic [3:0]       pend_ctrl;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;

  logic [WIDTH-1:0] exec_result;
  logic             exec_error;

  assign ready_out = (state == IDLE);
  assign accept    = valid_in && ready_out;
  assign start_mul = accept && (dec_ctrl == CTRL_MULTU);
  // Divide by zero never enters the iterative path; it completes like a
  // single-cycle op with the architected all-ones quotient.
  assign start_div = accept && (dec_ctrl == CTRL_DIVU) && (src_b != '0);
  assign last_step = (count == CNT_W'(WIDTH - 1));

  // Decode ALUOp/funct into the 4-bit control code. Loads/stores and
  // branches force ADD/SUB independent of the funct field.
  always_comb begin
    dec_ctrl = CTRL_INV;
    case (alu_op)
      2'd0: dec_ctrl = CTRL_ADD;
      2'd1: dec_ctrl = CTRL_SUB;
      default: begin
        case (func_code)
          6'd32:   dec_ctrl = CTRL_ADD;
          6'd34:   dec_ctrl = CTRL_SUB;
          6'd36:   dec_ctrl = CTRL_AND;
          6'd37:   dec_ctrl = CTRL_OR;
          6'd39:   dec_ctrl = CTRL_NOR;
          6'd42:   dec_ctrl = CTRL_SLT;
          6'd25:   dec_ctrl = CTRL_MULTU;
          6'd27:   dec_ctrl = CTRL_DIVU;
          6'd16:   dec_ctrl = CTRL_MFHI;
          6'd18:   dec_ctrl = CTRL_MFLO;
          default: dec_ctrl = CTRL_INV;
        endcase
      end
    endcase
  end

  // One shift-add multiply step: conditionally add the multiplicand into the
  // high half, then shift the {acc, multiplier} pair right by one. After
  // WIDTH steps {acc, q} holds the full 2*WIDTH product.
  always_comb begin
    mul_sum      = {1'b0, md_acc} + (md_q[0] ? {1'b0, md_operand} : '0);
    mul_acc_next = mul_sum[WIDTH:1];
    mul_q_next   = {mul_sum[0], md_q[WIDTH-1:1]};
  end

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor. The borrow out of the
  // WIDTH+1-bit difference says whether the trial went negative.
  always_comb begin
    div_shift    = {md_acc, md_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, md_operand};
    div_borrow   = div_diff[WIDTH];
    div_rem_next = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_q_next   = {md_q[WIDTH-2:0], ~div_borrow};
  end

  // Result of the pending single-cycle op. A DIVU only reaches this path when
  // its divisor was zero; MULTU never does.
  always_comb begin
    exec_result = '0;
    exec_error  = 1'b0;
    case (pend_ctrl)
      CTRL_ADD:  exec_result = pend_a + pend_b;
      CTRL_SUB:  exec_result = pend_a - pend_b;
      CTRL_AND:  exec_result = pend_a & pend_b;
      CTRL_OR:   exec_result = pend_a | pend_b;
      CTRL_NOR:  exec_result = ~(pend_a | pend_b);
      CTRL_SLT:  exec_result = {{(WIDTH-1){1'b0}}, ($signed(pend_a) < $signed(pend_b))};
      CTRL_MFHI: exec_result = hi;
      CTRL_MFLO: exec_result = lo;
      CTRL_DIVU: begin
        exec_result = '1;
        exec_error  = 1'b1;
      end
      default: begin
        exec_result = '0;
        exec_error  = 1'b1;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave IDLE only for a real iterative op, return on the
  // final iteration so the completion cycle is already ready for a new op.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_mul) begin
          state_next = MUL;
        end else if (start_div) begin
          state_next = DIV;
        end
      end
      MUL, DIV: begin
        if (last_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers. Accept only happens in IDLE and
  // iterations only in MUL/DIV, so the capture and step branches never
  // compete for md_*. A pending single-cycle op and a multicycle completion
  // can likewise never land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      md_acc       <= '0;
      md_q         <= '0;
      md_operand   <= '0;
      pend_valid   <= 1'b0;
      pend_ctrl    <= 4'd0;
      pend_a       <= '0;
      pend_b       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
      error        <= 1'b0;
      alu_ctrl     <= 4'd0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      result_valid <= 1'b0;
      pend_valid   <= 1'b0;

      if (accept) begin
        if (start_mul) begin
          md_acc     <= '0;
          md_q       <= src_b;
          md_operand <= src_a;
          count      <= '0;
        end else if (start_div) begin
          md_acc     <= '0;
          md_q       <= src_a;
          md_operand <= src_b;
          count      <= '0;
        end else begin
          pend_valid <= 1'b1;
          pend_ctrl  <= dec_ctrl;
          pend_a     <= src_a;
          pend_b     <= src_b;
        end
      end

      if (pend_valid) begin
        result       <= exec_result;
        zero         <= (exec_result == '0);
        error        <= exec_error;
        alu_ctrl     <= pend_ctrl;
        result_valid <= 1'b1;
        if (pend_ctrl == CTRL_DIVU) begin
          lo <= '1;
          hi <= pend_a;
        end
      end else if (state == MUL) begin
        md_acc <= mul_acc_next;
        md_q   <= mul_q_next;
        count  <= count + CNT_W'(1);
        if (last_step) begin
          hi           <= mul_acc_next;
          lo           <= mul_q_next;
          result       <= mul_q_next;
          zero         <= (mul_q_next == '0);
          error        <= 1'b0;
          alu_ctrl     <= CTRL_MULTU;
          result_valid <= 1'b1;
        end
      end else if (state == DIV) begin
        md_acc <= div_rem_next;
        md_q   <= div_q_next;
        count  <= count + CNT_W'(1);
        if (last_step) begin
          hi           <= div_rem_next;
          lo           <= div_q_next;
          result       <= div_q_next;
          zero         <= (div_q_next == '0);
          error        <= 1'b0;
          alu_ctrl     <= CTRL_DIVU;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_muldiv
//
// Self-checking bench for alu_ctrl_muldiv. Two instances are exercised: a
// 32-bit one and an 8-bit one. Expected results come from an arithmetic
// model (native *, /, %, signed compare) that tracks HI/LO in program order
// and knows how long each op keeps the unit busy. Every accepted op pushes
// an expectation (with the negedge index at which its pulse is due) into a
// per-instance queue; a monitor pops and compares on each result_valid.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_muldiv;

  logic clk;
  logic rst_n;

  logic        v32, rdy32, rv32, z32, e32;
  logic [1:0]  op32;
  logic [5:0]  fn32;
  logic [31:0] a32, b32, res32, hi32, lo32;
  logic [3:0]  c32;

  logic        v8, rdy8, rv8, z8, e8;
  logic [1:0]  op8;
  logic [5:0]  fn8;
  logic [7:0]  a8, b8, res8, hi8, lo8;
  logic [3:0]  c8;

  alu_ctrl_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid_in(v32), .alu_op(op32), .func_code(fn32),
    .src_a(a32), .src_b(b32), .ready_out(rdy32), .result(res32),
    .result_valid(rv32), .zero(z32), .error(e32), .alu_ctrl(c32),
    .hi(hi32), .lo(lo32)
  );

  alu_ctrl_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(v8), .alu_op(op8), .func_code(fn8),
    .src_a(a8), .src_b(b8), .ready_out(rdy8), .result(res8),
    .result_valid(rv8), .zero(z8), .error(e8), .alu_ctrl(c8),
    .hi(hi8), .lo(lo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  ctrl;
    logic        err;
    logic        zero;
  } exp_t;

  typedef struct {
    int          d;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        err;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];

  int          checks = 0;
  int          failures = 0;
  int          ncnt = 0;
  int          busy_until[2];
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];
  logic [5:0]  fn_list[10] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42,
                              6'd25, 6'd27, 6'd16, 6'd18};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q32.size() : q8.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? q32[0] : q8[0];
  endfunction

  function automatic void qpop(input int d);
    if (d == 0) void'(q32.pop_front());
    else void'(q8.pop_front());
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q32.push_back(e);
    else q8.push_back(e);
  endfunction

  // Control code for ALUOp/funct, straight from the decode table.
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    case (fn)
      6'd32:   return 4'd2;
      6'd34:   return 4'd6;
      6'd36:   return 4'd0;
      6'd37:   return 4'd1;
      6'd39:   return 4'd12;
      6'd42:   return 4'd7;
      6'd25:   return 4'd8;
      6'd27:   return 4'd9;
      6'd16:   return 4'd10;
      6'd18:   return 4'd11;
      default: return 4'd15;
    endcase
  endfunction

  function automatic longint to_signed(input longint unsigned v, input int w);
    if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Each negedge: advance the timebase, then match pulses against the queue.
  task automatic monitor_dut(input int d);
    exp_t        e;
    logic        v, z, er;
    logic [31:0] r, h, l;
    logic [3:0]  c;
    string       tag;
    tag = (d == 0) ? "w32" : "w8";
    if (d == 0) begin
      v = rv32; r = res32; h = hi32; l = lo32; c = c32; z = z32; er = e32;
    end else begin
      v = rv8; r = {24'b0, res8}; h = {24'b0, hi8}; l = {24'b0, lo8};
      c = c8; z = z8; er = e8;
    end
    if (v) begin
      if (qsize(d) == 0) begin
        check_output({tag, " unexpected_result_valid"}, 32'd1, 32'd0);
      end else begin
        e = qfront(d);
        if (e.due == ncnt) begin
          qpop(d);
          check_output({tag, " result"}, r, e.res);
          check_output({tag, " zero"}, {31'b0, z}, {31'b0, e.zero});
          check_output({tag, " error"}, {31'b0, er}, {31'b0, e.err});
          check_output({tag, " alu_ctrl"}, {28'b0, c}, {28'b0, e.ctrl});
          check_output({tag, " hi"}, h, e.hi);
          check_output({tag, " lo"}, l, e.lo);
        end else begin
          check_output({tag, " pulse_cycle"}, ncnt, e.due);
        end
      end
    end
    if (qsize(d) > 0) begin
      e = qfront(d);
      if (e.due < ncnt) begin
        check_output({tag, " missing_result_valid"}, 32'd0, 32'd1);
        qpop(d);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncnt++;
      if (rst_n) begin
        monitor_dut(0);
        monitor_dut(1);
      end
    end
  end

  // Drive one request for a cycle. Acceptance is decided by the model's own
  // busy window; the DUT's ready_out is only compared against it.
  task automatic apply_stimulus(input int d, input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                input bit use_tab, input logic [31:0] t_res,
                                input logic [3:0] t_ctrl, input logic t_err);
    int              w;
    longint unsigned mask, la, lb, prod;
    logic [3:0]      ctrl;
    exp_t            e;
    bit              mready, multi;
    logic            dut_rdy;
    string           tag;
    w    = (d == 0) ? 32 : 8;
    mask = (d == 0) ? 64'hFFFF_FFFF : 64'hFF;
    tag  = (d == 0) ? "w32" : "w8";
    la   = longint'(a) & mask;
    lb   = longint'(b) & mask;
    @(negedge clk);
    #1;
    v32 = (d == 0);
    v8  = (d == 1);
    if (d == 0) begin
      op32 = op; fn32 = fn; a32 = la[31:0]; b32 = lb[31:0];
    end else begin
      op8 = op; fn8 = fn; a8 = la[7:0]; b8 = lb[7:0];
    end
    dut_rdy = (d == 0) ? rdy32 : rdy8;
    mready  = (ncnt >= busy_until[d]);
    check_output({tag, " ready_out"}, {31'b0, dut_rdy}, {31'b0, mready});
    if (mready) begin
      ctrl  = ref_ctrl(op, fn);
      e.err = 1'b0;
      e.res = '0;
      multi = 1'b0;
      case (ctrl)
        4'd2:  e.res = 32'((la + lb) & mask);
        4'd6:  e.res = 32'((la - lb) & mask);
        4'd0:  e.res = 32'(la & lb);
        4'd1:  e.res = 32'(la | lb);
        4'd12: e.res = 32'(~(la | lb) & mask);
        4'd7:  e.res = (to_signed(la, w) < to_signed(lb, w)) ? 32'd1 : 32'd0;
        4'd8: begin
          prod   = la * lb;
          mhi[d] = 32'((prod >> w) & mask);
          mlo[d] = 32'(prod & mask);
          e.res  = mlo[d];
          multi  = 1'b1;
        end
        4'd9: begin
          if (lb == 0) begin
            mlo[d] = 32'(mask);
            mhi[d] = 32'(la);
            e.res  = 32'(mask);
            e.err  = 1'b1;
          end else begin
            mlo[d] = 32'(la / lb);
            mhi[d] = 32'(la % lb);
            e.res  = mlo[d];
            multi  = 1'b1;
          end
        end
        4'd10: e.res = mhi[d];
        4'd11: e.res = mlo[d];
        default: begin
          e.res = '0;
          e.err = 1'b1;
        end
      endcase
      e.ctrl = ctrl;
      e.hi   = mhi[d];
      e.lo   = mlo[d];
      if (use_tab) begin
        e.res  = t_res;
        e.ctrl = t_ctrl;
        e.err  = t_err;
      end
      e.zero = (e.res == 0);
      e.due  = multi ? ncnt + 1 + w : ncnt + 2;
      if (multi) busy_until[d] = ncnt + 1 + w;
      qpush(d, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      v32 = 1'b0;
      v8  = 1'b0;
      check_output("w32 ready_out", {31'b0, rdy32}, {31'b0, (ncnt >= busy_until[0])});
      check_output("w8 ready_out", {31'b0, rdy8}, {31'b0, (ncnt >= busy_until[1])});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    v32 = 1'b0;
    v8  = 1'b0;
    q32.delete();
    q8.delete();
    for (int d = 0; d < 2; d++) begin
      busy_until[d] = 0;
      mhi[d] = '0;
      mlo[d] = '0;
    end
    #1;
    check_output("w32 reset result", res32, 32'd0);
    check_output("w32 reset result_valid", {31'b0, rv32}, 32'd0);
    check_output("w32 reset zero", {31'b0, z32}, 32'd0);
    check_output("w32 reset error", {31'b0, e32}, 32'd0);
    check_output("w32 reset alu_ctrl", {28'b0, c32}, 32'd0);
    check_output("w32 reset hi", hi32, 32'd0);
    check_output("w32 reset lo", lo32, 32'd0);
    check_output("w32 reset ready_out", {31'b0, rdy32}, 32'd1);
    check_output("w8 reset result", {24'b0, res8}, 32'd0);
    check_output("w8 reset hi", {24'b0, hi8}, 32'd0);
    check_output("w8 reset lo", {24'b0, lo8}, 32'd0);
    check_output("w8 reset ready_out", {31'b0, rdy8}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t        tab[11];
  logic [1:0]  r_op;
  logic [5:0]  r_fn;
  logic [31:0] r_a, r_b;
  int          pick;

  initial begin
    rst_n = 1'b0;
    v32 = 1'b0; op32 = '0; fn32 = '0; a32 = '0; b32 = '0;
    v8  = 1'b0; op8  = '0; fn8  = '0; a8  = '0; b8  = '0;
    for (int d = 0; d < 2; d++) begin
      busy_until[d] = 0;
      mhi[d] = '0;
      mlo[d] = '0;
    end

    tab[0]  = '{0, 2'd0, 6'd39, 32'd5,         32'd3,         32'd8,         4'd2,  1'b0};
    tab[1]  = '{0, 2'd2, 6'd34, 32'd5,         32'd3,         32'd2,         4'd6,  1'b0};
    tab[2]  = '{0, 2'd2, 6'd39, 32'd0,         32'd0,         32'hFFFF_FFFF, 4'd12, 1'b0};
    tab[3]  = '{0, 2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1,         32'd1,         4'd7,  1'b0};
    tab[4]  = '{0, 2'd2, 6'd40, 32'd7,         32'd9,         32'd0,         4'd15, 1'b1};
    tab[5]  = '{0, 2'd1, 6'd32, 32'd9,         32'd4,         32'd5,         4'd6,  1'b0};
    tab[6]  = '{0, 2'd3, 6'd36, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'd0,  1'b0};
    tab[7]  = '{0, 2'd3, 6'd37, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 4'd1,  1'b0};
    tab[8]  = '{1, 2'd2, 6'd32, 32'h0000_00FF, 32'd1,         32'd0,         4'd2,  1'b0};
    tab[9]  = '{1, 2'd2, 6'd42, 32'h0000_0080, 32'h0000_007F, 32'd1,         4'd7,  1'b0};
    tab[10] = '{1, 2'd2, 6'd42, 32'h0000_007F, 32'h0000_0080, 32'd0,         4'd7,  1'b0};

    do_reset();
    idle(2);

    // Decode sweep, issued back to back.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(tab[i].d, tab[i].op, tab[i].fn, tab[i].a, tab[i].b,
                     1'b1, tab[i].res, tab[i].ctrl, tab[i].err);
    end
    idle(3);

    // Three consecutive single-cycle ops; the SUB result is zero.
    apply_stimulus(0, 2'd2, 6'd32, 32'd1, 32'd2, 1'b1, 32'd3, 4'd2, 1'b0);
    apply_stimulus(0, 2'd2, 6'd34, 32'd3, 32'd3, 1'b1, 32'd0, 4'd6, 1'b0);
    apply_stimulus(0, 2'd2, 6'd37, 32'd4, 32'd1, 1'b1, 32'd5, 4'd1, 1'b0);
    idle(3);

    // MULTU with valid_in held through the busy window, then MFHI/MFLO.
    apply_stimulus(0, 2'd2, 6'd25, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 4'd8, 1'b0);
    repeat (32) apply_stimulus(0, 2'd2, 6'd32, 32'd1, 32'd1, 1'b0, 32'd0, 4'd0, 1'b0);
    apply_stimulus(0, 2'd2, 6'd16, 32'd0, 32'd0, 1'b1, 32'd1, 4'd10, 1'b0);
    apply_stimulus(0, 2'd2, 6'd18, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE, 4'd11, 1'b0);
    idle(3);

    // DIVU 100/7, then divide by zero.
    apply_stimulus(0, 2'd2, 6'd27, 32'd100, 32'd7, 1'b1, 32'd14, 4'd9, 1'b0);
    idle(32);
    apply_stimulus(0, 2'd2, 6'd16, 32'd0, 32'd0, 1'b1, 32'd2, 4'd10, 1'b0);
    apply_stimulus(0, 2'd2, 6'd27, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'd9, 1'b1);
    apply_stimulus(0, 2'd2, 6'd16, 32'd0, 32'd0, 1'b1, 32'd9, 4'd10, 1'b0);
    apply_stimulus(0, 2'd2, 6'd18, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'd11, 1'b0);
    idle(3);

    // Narrow instance: MULTU 200 x 3 = 0x0258.
    apply_stimulus(1, 2'd2, 6'd25, 32'd200, 32'd3, 1'b1, 32'h58, 4'd8, 1'b0);
    idle(8);
    apply_stimulus(1, 2'd2, 6'd16, 32'd0, 32'd0, 1'b1, 32'h02, 4'd10, 1'b0);
    idle(3);

    // Reset five cycles into a MULTU: no pulse afterwards, HI/LO cleared.
    apply_stimulus(0, 2'd2, 6'd25, 32'd5, 32'd6, 1'b1, 32'd30, 4'd8, 1'b0);
    idle(4);
    do_reset();
    idle(40);
    apply_stimulus(0, 2'd2, 6'd16, 32'd0, 32'd0, 1'b1, 32'd0, 4'd10, 1'b0);
    idle(3);

    // Randomized traffic against the model, including requests while busy.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          idle(1);
        end else begin
          pick = $urandom_range(0, 10);
          r_fn = (pick < 10) ? fn_list[pick] : 6'($urandom_range(0, 63));
          r_op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
          r_a  = $urandom;
          if ($urandom_range(0, 5) == 0) r_b = 32'd0;
          else if ($urandom_range(0, 2) == 0) r_b = 32'($urandom_range(1, 20));
          else r_b = $urandom;
          apply_stimulus(d, r_op, r_fn, r_a, r_b, 1'b0, 32'd0, 4'd0, 1'b0);
        end
      end
      idle(40);
    end

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Parametrised ALU control plus execute unit for the datapath. It decodes ALUOp/funct into the team's 4-bit ALU control code and executes single-cycle ALU ops. It adds iterative unsigned multiply/divide with HI/LO registers behind a valid/ready handshake. It sits between the main control unit / register-file read stage and the writeback stage.

## Interface
- WIDTH, 32, datapath width in bits (>= 4); also the multiply/divide iteration count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  operation request; accepted when valid_in && ready_out
- alu_op  in  2  0: add (LW/SW), 1: sub (BEQ), 2/3: R-type (decode func_code)
- func_code  in  6  R-type funct field
- src_a, src_b  in  WIDTH  operands
- ready_out  out  1  high when the block can accept an operation (state IDLE)
- result  out  WIDTH  registered result; held until next result_valid
- result_valid  out  1  one-cycle pulse: result/zero/error/alu_ctrl are valid
- zero  out  1  result == 0
- error  out  1  unknown funct or divide-by-zero; qualified by result_valid
- alu_ctrl  out  4  control code of the completed operation
- hi, lo  out  WIDTH  architectural HI/LO registers

## Operation
- Control codes: ADD 2, SUB 6, AND 0, OR 1, NOR 12, SLT 7, MULTU 8, DIVU 9, MFHI 10, MFLO 11, invalid 15.
- alu_op 0 gives ADD and alu_op 1 gives SUB, regardless of func_code.
- alu_op 2/3 decodes func_code: 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT, 25 MULTU, 27 DIVU, 16 MFHI, 18 MFLO, others invalid.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT is signed two's-complement; result = 1 or 0, zero-extended.
- MFHI returns hi and MFLO returns lo; neither changes hi or lo.
- Invalid funct: result 0, alu_ctrl 15, error 1; hi and lo are unchanged.
- MULTU: unsigned shift-add over WIDTH iterations; the 2*WIDTH product goes to {hi, lo}; result = low WIDTH bits.
- DIVU: unsigned restoring divide over WIDTH iterations; lo = quotient, hi = remainder; result = quotient.
- DIVU with src_b == 0: completes as a single-cycle op with lo = all ones, hi = src_a, result = all ones, error 1.
- The FSM has three states: IDLE, MUL and DIV.
  - IDLE --accept MULTU--> MUL.
  - IDLE --accept DIVU (src_b != 0)--> DIV.
  - Any other accept stays in IDLE.
  - MUL/DIV --iteration counter reaches final step--> IDLE.
- Operands are captured at accept; src_a and src_b may change afterwards.
- valid_in while ready_out is low is ignored and has no side effects.

## Timing
- Reset, asynchronous with rst_n low:
  - result, hi, lo = 0.
  - result_valid, zero, error = 0; alu_ctrl = 0.
  - state = IDLE, so ready_out = 1 combinationally from the state.
- Reset mid-multiply/divide aborts the operation. No result_valid is issued, and hi/lo are cleared.
- Single-cycle ops: accept at edge N, result_valid pulse after edge N+1. ready_out stays high, giving back-to-back throughput of 1 op/cycle.
- MULTU/DIVU: accept at edge N, ready_out low after edge N.
  - hi, lo, result and result_valid update at edge N+WIDTH.
  - ready_out returns high in that same cycle.
- An op accepted in the completion cycle sees the new hi/lo. For example, MFHI immediately after MULTU returns the new hi.
- result_valid is never high for two cycles from a single multicycle op. Consecutive single-cycle ops pulse on consecutive cycles.

## Test plan
- Reset, WIDTH=32: assert rst_n=0 mid-MULTU (cycle 5) -> all outputs 0, ready_out=1, no result_valid afterward; hi=lo=0.
- Decode sweep: alu_op=0, func=39, a=5, b=3 -> result 8, alu_ctrl 2. alu_op=2: func 34 with 5,3 gives 2; func 39 with 0,0 gives 0xFFFFFFFF/ctrl 12; func 42 with 0xFFFFFFFF,1 gives 1/ctrl 7; func 40 gives result 0, error 1, ctrl 15.
- Back-to-back: ADD, SUB (3,3), OR on consecutive cycles -> three consecutive result_valid pulses; the SUB pulse has zero=1.
- MULTU 0xFFFFFFFF x 2 -> ready_out low for 32 cycles; then hi=1, lo=0xFFFFFFFE, result_valid after exactly 32 edges. valid_in held during busy is ignored; MFHI issued at completion returns 1.
- DIVU 100/7 -> lo=14, hi=2 after 32 edges. DIVU 9/0 -> 1-cycle result 0xFFFFFFFF, hi=9, error=1.
- WIDTH=8 instance: MULTU 200 x 3 -> hi=0x02, lo=0x58 after 8 edges. ADD 0xFF+1 -> result 0, zero=1.
